// File: rtl/dds_channel_bank_pkg.sv
// Shared types and constants for the multi-channel DDS bank and its SPI register port.
package dds_pkg;

  typedef enum logic [1:0] {
    REG_FREQ  = 2'b00,
    REG_PHASE = 2'b01,
    REG_CTRL  = 2'b10,
    REG_RSVD  = 2'b11
  } reg_type_e;

  localparam int unsigned HEADER_LEN  = 8;
  localparam int unsigned CTRL_LEN    = 8;
  localparam int unsigned CH_BITS     = 6;
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;

  // Total frame length (header + payload) for a register type; 0 marks an unusable type.
  function automatic int unsigned frame_len(reg_type_e t, int unsigned acc_len,
                                            int unsigned phase_len);
    unique case (t)
      REG_FREQ:  return HEADER_LEN + acc_len;
      REG_PHASE: return HEADER_LEN + phase_len;
      REG_CTRL:  return HEADER_LEN + CTRL_LEN;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/dds_channel_bank_if.sv
// SPI write-port pins of the DDS channel bank, all asynchronous to sys_clk.
interface dds_channel_bank_if;

  logic spi_clk;
  logic spi_data;
  logic spi_cs_n;

  modport master (output spi_clk, output spi_data, output spi_cs_n);
  modport slave  (input  spi_clk, input  spi_data, input  spi_cs_n);

endinterface

// File: rtl/dds_channel_bank_spi_rx.sv
// Oversampled SPI receiver: synchronizes the pins, shifts frames in and validates them at cs_n rise.
module dds_spi_rx
  import dds_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ACC_LENGTH   = 48,
  parameter int unsigned PHASE_LENGTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  dds_channel_bank_if.slave     spi,
  output logic                  commit,
  output reg_type_e             commit_type,
  output logic [CH_BITS-1:0]    commit_ch,
  output logic [ACC_LENGTH-1:0] commit_payload,
  output logic                  err
);

  localparam int unsigned MaxBits = HEADER_LEN + ACC_LENGTH;
  localparam int unsigned CntW    = $clog2(MaxBits + 2);

  // [1:0] form the synchronizer, [2] is the edge-detect history
  logic [2:0]            clk_sync_q;
  logic [2:0]            data_sync_q;
  logic [2:0]            cs_sync_q;
  logic                  in_frame_q;
  logic [CntW-1:0]       cnt_q;
  logic [ACC_LENGTH-1:0] sr_q;
  logic [HEADER_LEN-1:0] hdr_q;

  logic clk_rise, cs_fall, cs_rise;

  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      cs_sync_q   <= '0;
      in_frame_q  <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      hdr_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], spi.spi_clk};
      data_sync_q <= {data_sync_q[1:0], spi.spi_data};
      cs_sync_q   <= {cs_sync_q[1:0], spi.spi_cs_n};
      // A frame only counts once its cs_n fall has been seen, so a frame cut by reset is dropped
      if (cs_fall) begin
        in_frame_q <= 1'b1;
        cnt_q      <= '0;
        sr_q       <= '0;
        hdr_q      <= '0;
      end else if (cs_rise) begin
        in_frame_q <= 1'b0;
      end else if (in_frame_q && clk_rise) begin
        sr_q <= {sr_q[ACC_LENGTH-2:0], data_sync_q[2]};
        if (cnt_q < CntW'(HEADER_LEN)) begin
          hdr_q <= {hdr_q[HEADER_LEN-2:0], data_sync_q[2]};
        end
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  reg_type_e       hdr_type;
  logic [CntW-1:0] exp_len;
  logic            len_ok;
  logic            ch_ok;
  logic            fire;

  always_comb begin
    hdr_type = reg_type_e'(hdr_q[HEADER_LEN-1 -: 2]);
    exp_len  = CntW'(frame_len(hdr_type, ACC_LENGTH, PHASE_LENGTH));
    len_ok   = (hdr_type != REG_RSVD) && (cnt_q == exp_len);
    ch_ok    = 32'(hdr_q[CH_BITS-1:0]) < NUM_CH;
    fire     = cs_rise && in_frame_q && (cnt_q != '0);
  end

  assign commit         = fire && len_ok && ch_ok;
  assign err            = fire && !(len_ok && ch_ok);
  assign commit_type    = hdr_type;
  assign commit_ch      = hdr_q[CH_BITS-1:0];
  assign commit_payload = sr_q;

endmodule

// File: rtl/dds_channel_bank.sv
// Bank of NUM_CH phase accumulators with double-buffered registers written over one SPI port.
module dds_channel_bank
  import dds_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ACC_LENGTH   = 48,
  parameter int unsigned PHASE_LENGTH = 16
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  dds_channel_bank_if.slave              spi,
  input  logic                           update,
  output logic [NUM_CH*PHASE_LENGTH-1:0] phase_out,
  output logic                           frame_done,
  output logic                           frame_err
);

  logic                  commit;
  logic                  err;
  reg_type_e             commit_type;
  logic [CH_BITS-1:0]    commit_ch;
  logic [ACC_LENGTH-1:0] commit_payload;

  dds_spi_rx #(
    .NUM_CH       (NUM_CH),
    .ACC_LENGTH   (ACC_LENGTH),
    .PHASE_LENGTH (PHASE_LENGTH)
  ) u_spi_rx (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .spi            (spi),
    .commit         (commit),
    .commit_type    (commit_type),
    .commit_ch      (commit_ch),
    .commit_payload (commit_payload),
    .err            (err)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= commit;
      frame_err  <= err;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ACC_LENGTH-1:0]   freq_sh_q, freq_sh_d, freq_act_q;
    logic [PHASE_LENGTH-1:0] ph_sh_q, ph_sh_d, ph_act_q;
    logic                    en_sh_q, en_sh_d, en_act_q;
    logic                    clr_sh_q, clr_sh_d, clr_act_q;
    logic [ACC_LENGTH-1:0]   acc_q;
    logic [PHASE_LENGTH-1:0] phase_q;
    logic                    sel;

    assign sel = commit && (commit_ch == CH_BITS'(k));

    // The *_sh_d values feed the active copy so a same-cycle commit wins over the old shadow
    always_comb begin
      freq_sh_d = freq_sh_q;
      ph_sh_d   = ph_sh_q;
      en_sh_d   = en_sh_q;
      clr_sh_d  = clr_sh_q;
      if (sel) begin
        unique case (commit_type)
          REG_FREQ:  freq_sh_d = commit_payload;
          REG_PHASE: ph_sh_d   = commit_payload[PHASE_LENGTH-1:0];
          REG_CTRL: begin
            en_sh_d  = commit_payload[CTRL_ENABLE];
            clr_sh_d = commit_payload[CTRL_CLEAR];
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        freq_sh_q  <= '0;
        ph_sh_q    <= '0;
        en_sh_q    <= 1'b0;
        clr_sh_q   <= 1'b0;
        freq_act_q <= '0;
        ph_act_q   <= '0;
        en_act_q   <= 1'b0;
        clr_act_q  <= 1'b0;
        acc_q      <= '0;
        phase_q    <= '0;
      end else begin
        freq_sh_q <= freq_sh_d;
        ph_sh_q   <= ph_sh_d;
        en_sh_q   <= en_sh_d;
        clr_sh_q  <= clr_sh_d;
        if (update) begin
          freq_act_q <= freq_sh_d;
          ph_act_q   <= ph_sh_d;
          en_act_q   <= en_sh_d;
          clr_act_q  <= clr_sh_d;
        end
        if (update && clr_sh_d) begin
          acc_q <= '0;
        end else if (en_act_q) begin
          acc_q <= acc_q + freq_act_q;
        end
        phase_q <= acc_q[ACC_LENGTH-1 -: PHASE_LENGTH] + ph_act_q;
      end
    end

    assign phase_out[k*PHASE_LENGTH +: PHASE_LENGTH] = phase_q;
  end

endmodule

// File: doc/dds_channel_bank.md
Name: dds_channel_bank

Overview:
Multi-channel successor to the single DDS phase path. NUM_CH independent phase accumulators share one SPI write port. The port is oversampled entirely in the sys_clk domain. Each channel has double-buffered frequency, phase-offset and control registers, and a global update strobe applies all of them atomically. The registered phase outputs feed per-channel waveform shapers downstream.

Parameters:
NUM_CH, 4, number of channels (1..64)
ACC_LENGTH, 48, accumulator / frequency word width
PHASE_LENGTH, 16, phase output and offset width (must be < ACC_LENGTH)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
spi_clk  in  1  async SPI clock, mode 0, sampled by sys_clk
spi_data  in  1  async SPI MOSI, MSB first
spi_cs_n  in  1  async SPI frame select, active low
update  in  1  one-cycle strobe: copy all shadow regs to active regs
phase_out  out  NUM_CH*PHASE_LENGTH  channel k at [k*PHASE_LENGTH +: PHASE_LENGTH], registered
frame_done  out  1  one-cycle pulse: valid frame committed to shadow
frame_err  out  1  one-cycle pulse: frame discarded

Behaviour:
- One clock (sys_clk). Reset is synchronous, active-low (sys_rst_n).
- Reset clears to 0: all accumulators, shadow and active regs, synchronizers, bit counter, phase_out, frame_done, frame_err. Control enable resets to 0, so all channels hold at 0.
- SPI input path:
  - spi_clk, spi_data and spi_cs_n each pass through a 2-flop synchronizer, then a 1-flop edge detect.
  - spi_clk high and low times must each be >= 3 sys_clk periods.
- SPI framing:
  - A synced cs_n fall clears the bit counter and shift register.
  - Data is sampled on each synced spi_clk rise while cs_n is low.
  - Header is 8 bits: [7:6] type, [5:0] channel. Type 00 = freq (ACC_LENGTH payload), 01 = phase (PHASE_LENGTH payload), 10 = ctrl (8 payload), 11 = reserved.
  - Ctrl bit0 = enable, bit1 = clear_on_update, bits 7:2 ignored.
- Frame end (synced cs_n rise):
  - Valid frame (bit count == 8 + payload length, type != 11, channel < NUM_CH): write payload to that channel's shadow reg and pulse frame_done.
  - Any other frame: pulse frame_err, no register change.
  - Extra clocks beyond the expected length make the frame invalid.
  - Commit happens exactly 3 sys_clk edges after spi_cs_n rises at the pin.
  - cs_n rising with zero bits received produces no pulse.
- Update:
  - On update = 1, every channel copies shadow -> active in the same cycle.
  - If a commit lands in the same cycle, the newly committed value is the one applied.
  - Shadow writes never affect outputs until an update.
- Accumulator, per cycle:
  - If update and the next active clear_on_update = 1: acc <= 0 (overrides increment).
  - Else if active enable = 1: acc <= acc + freq_active, modulo 2^ACC_LENGTH.
  - Else acc holds.
- Output: phase_out_k <= acc[ACC_LENGTH-1 -: PHASE_LENGTH] + phase_active, modulo 2^PHASE_LENGTH. This is one cycle of latency after acc.
- Reset mid-frame: discard the partial frame with no frame_err. The next frame after reset parses normally.
- update held high for multiple cycles applies shadows every cycle. This is legal.

Decomposition:
- Package dds_pkg:
  - reg-type enum (REG_FREQ, REG_PHASE, REG_CTRL, REG_RSVD)
  - HEADER_LEN = 8, CTRL_LEN = 8, CH_BITS = 6
  - ctrl bit indices CTRL_ENABLE = 0, CTRL_CLEAR = 1
- Sub-module dds_spi_rx: synchronizers, edge detect, bit counter, shift register and frame validation. It outputs commit strobe, type, channel, payload and err.
- Channel registers and accumulators live in a generate loop in dds_channel_bank.

Test Plan:
1. Reset: sys_rst_n = 0 for 5 cycles while toggling SPI -> phase_out all 0; frame_done and frame_err stay 0; outputs stay 0 after release with no writes.
2. Write freq ch1 = 0x0001_0000_0000, then ctrl ch1 = 0x01, then pulse update:
   - phase_out ch1 reads 0x0000, 0x0001, 0x0002, ... one step per cycle.
   - phase_out ch1 stays 0 before the update.
   - ch0, ch2 and ch3 stay 0.
3. Write phase ch2 = 0x4000, ctrl ch2 = 0x01, freq 0, pulse update -> phase_out ch2 = 0x4000 two cycles after update and constant thereafter.
4. Wrap: freq ch0 = 0x8000_0000_0000 with enable -> phase_out ch0 alternates 0x0000 and 0x8000.
5. Error cases, each -> one frame_err pulse, no frame_done, shadow unchanged (checked via a later update):
   - freq frame cut at 30 bits
   - header channel = 5 with NUM_CH = 4
   - type 11
6. Commit/update race and clear:
   - Time update to coincide with the commit of ctrl ch3 = 0x03 -> ch3 acc clears that cycle and ch3 runs with enable = 1.
   - Assert reset mid-frame -> the following valid frame gives frame_done.
